// File: rtl/if_id_stage.sv
// IF/ID pipeline register with ID-stage hazard detection and early beq/bne resolution.
// Returns stall, branch_confirm and branch_addr to fetch, and a bubble request to ID/EX.
module if_id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CPUCLK,
  input  logic             reset,
  input  logic [31:0]      PC_in,
  input  logic [31:0]      PC_add_4_in,
  input  logic [31:0]      inst_from_rom,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_write_reg,
  input  logic             exmem_mem_read,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_write_reg,
  input  logic [31:0]      exmem_alu_result,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_add_4,
  output logic [31:0]      ifid_inst,
  output logic             ifid_valid,
  output logic             stall,
  output logic             bubble_idex,
  output logic             branch_confirm,
  output logic [31:0]      branch_addr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        is_branch;
  logic        uses_rt;
  logic        load_use_stall;
  logic        branch_stall;
  logic        idex_hits_rs;
  logic        idex_hits_rt;
  logic        exmem_hits_rs;
  logic        exmem_hits_rt;
  logic        exmem_fwd_ok;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        operands_equal;

  assign op  = ifid_inst[31:26];
  assign rs  = ifid_inst[25:21];
  assign rt  = ifid_inst[20:16];
  assign imm = ifid_inst[15:0];

  // Hazard detection, operand forwarding from EX/MEM, and branch resolution
  always_comb begin
    is_branch      = (op == OP_BEQ) || (op == OP_BNE);
    uses_rt        = (op == OP_RTYPE) || is_branch || (op == OP_SW);
    idex_hits_rs   = (idex_write_reg != 5'd0) && (idex_write_reg == rs);
    idex_hits_rt   = (idex_write_reg != 5'd0) && (idex_write_reg == rt);
    exmem_hits_rs  = (exmem_write_reg != 5'd0) && (exmem_write_reg == rs);
    exmem_hits_rt  = (exmem_write_reg != 5'd0) && (exmem_write_reg == rt);

    load_use_stall = idex_mem_read && (idex_hits_rs || (uses_rt && idex_hits_rt));
    // A branch compares in ID, so an EX-stage result or a MEM-stage load is too late
    branch_stall   = is_branch &&
                     ((idex_reg_write && (idex_hits_rs || idex_hits_rt)) ||
                      (exmem_mem_read && (exmem_hits_rs || exmem_hits_rt)));
    stall          = load_use_stall || branch_stall;
    bubble_idex    = stall;

    exmem_fwd_ok   = exmem_reg_write && !exmem_mem_read;
    rs_val         = (exmem_fwd_ok && exmem_hits_rs) ? exmem_alu_result : rs_data;
    rt_val         = (exmem_fwd_ok && exmem_hits_rt) ? exmem_alu_result : rt_data;
    operands_equal = (rs_val == rt_val);

    branch_confirm = ifid_valid && is_branch && !stall &&
                     ((op == OP_BEQ) ? operands_equal : !operands_equal);
    branch_addr    = ifid_pc_add_4 + {{14{imm[15]}}, imm, 2'b00};
  end

  // Pipeline register: flush beats stall beats normal load
  always_ff @(posedge CPUCLK or posedge reset) begin
    if (reset) begin
      ifid_pc       <= 32'd0;
      ifid_pc_add_4 <= 32'd0;
      ifid_inst     <= NOP_INST;
      ifid_valid    <= 1'b0;
      stall_cycles  <= '0;
      flush_count   <= '0;
    end else if (branch_confirm) begin
      ifid_pc       <= PC_in;
      ifid_pc_add_4 <= PC_add_4_in;
      ifid_inst     <= NOP_INST;
      ifid_valid    <= 1'b0;
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end else if (stall) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      ifid_pc       <= PC_in;
      ifid_pc_add_4 <= PC_add_4_in;
      ifid_inst     <= inst_from_rom;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; expected values are queued as stimulus is driven
// and popped against DUT outputs sampled 1 time unit after the clock edge or input change.
module tb_if_id_stage;

  logic        CPUCLK = 1'b0;
  logic        reset;
  logic [31:0] PC_in, PC_add_4_in, inst_from_rom, rs_data, rt_data;
  logic        idex_mem_read, idex_reg_write;
  logic [4:0]  idex_write_reg;
  logic        exmem_mem_read, exmem_reg_write;
  logic [4:0]  exmem_write_reg;
  logic [31:0] exmem_alu_result;
  logic [31:0] ifid_pc, ifid_pc_add_4, ifid_inst;
  logic        ifid_valid, stall, bubble_idex, branch_confirm;
  logic [31:0] branch_addr, stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  if_id_stage #(.NOP_INST(32'h0000_0000), .CNT_W(32)) dut (
    .CPUCLK(CPUCLK), .reset(reset),
    .PC_in(PC_in), .PC_add_4_in(PC_add_4_in), .inst_from_rom(inst_from_rom),
    .rs_data(rs_data), .rt_data(rt_data),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
    .idex_write_reg(idex_write_reg),
    .exmem_mem_read(exmem_mem_read), .exmem_reg_write(exmem_reg_write),
    .exmem_write_reg(exmem_write_reg), .exmem_alu_result(exmem_alu_result),
    .ifid_pc(ifid_pc), .ifid_pc_add_4(ifid_pc_add_4), .ifid_inst(ifid_inst),
    .ifid_valid(ifid_valid), .stall(stall), .bubble_idex(bubble_idex),
    .branch_confirm(branch_confirm), .branch_addr(branch_addr),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CPUCLK = ~CPUCLK;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: got %h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CPUCLK);
    #1;
  endtask

  task automatic expect_reset_state(input string pfx);
    push({pfx, "_pc"}, 32'h0);
    push({pfx, "_pc4"}, 32'h0);
    push({pfx, "_inst"}, 32'h0);
    push({pfx, "_valid"}, 32'h0);
    push({pfx, "_stall"}, 32'h0);
    push({pfx, "_confirm"}, 32'h0);
    push({pfx, "_stall_cycles"}, 32'h0);
    push({pfx, "_flush_count"}, 32'h0);
    pop_chk(ifid_pc);
    pop_chk(ifid_pc_add_4);
    pop_chk(ifid_inst);
    pop_chk(32'(ifid_valid));
    pop_chk(32'(stall));
    pop_chk(32'(branch_confirm));
    pop_chk(stall_cycles);
    pop_chk(flush_count);
  endtask

  initial begin
    reset = 1'b1;
    PC_in = '0; PC_add_4_in = '0; inst_from_rom = '0;
    rs_data = '0; rt_data = '0;
    idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_write_reg = '0;
    exmem_mem_read = 1'b0; exmem_reg_write = 1'b0; exmem_write_reg = '0;
    exmem_alu_result = '0;
    #3;
    expect_reset_state("reset");
    push("reset_branch_addr", 32'h0);
    pop_chk(branch_addr);
    #9 reset = 1'b0;

    // addi $8,$0,5 at PC 0 appears after one edge
    PC_in = 32'h0; PC_add_4_in = 32'h4; inst_from_rom = 32'h2008_0005;
    tick();
    push("fetch_inst", 32'h2008_0005); pop_chk(ifid_inst);
    push("fetch_pc", 32'h0);           pop_chk(ifid_pc);
    push("fetch_pc4", 32'h4);          pop_chk(ifid_pc_add_4);
    push("fetch_valid", 32'h1);        pop_chk(32'(ifid_valid));
    push("fetch_stall", 32'h0);        pop_chk(32'(stall));

    // load-use: lw $8 in EX, add $9,$8,$10 in ID
    PC_in = 32'h4; PC_add_4_in = 32'h8; inst_from_rom = 32'h010A_4820;
    tick();
    idex_mem_read = 1'b1; idex_write_reg = 5'd8;
    PC_in = 32'h8; PC_add_4_in = 32'hC; inst_from_rom = 32'h1234_5678;
    #1;
    push("lu_stall", 32'h1);  pop_chk(32'(stall));
    push("lu_bubble", 32'h1); pop_chk(32'(bubble_idex));
    tick();
    push("lu_hold_inst", 32'h010A_4820); pop_chk(ifid_inst);
    push("lu_hold_pc", 32'h4);           pop_chk(ifid_pc);
    push("lu_stall_cycles", 32'h1);      pop_chk(stall_cycles);
    idex_mem_read = 1'b0;
    #1;
    push("lu_release", 32'h0); pop_chk(32'(stall));

    // beq $1,$2,+3 taken with equal register reads
    PC_in = 32'hC; PC_add_4_in = 32'h10; inst_from_rom = 32'h1022_0003;
    rs_data = 32'd7; rt_data = 32'd7;
    tick();
    push("beq_confirm", 32'h1);  pop_chk(32'(branch_confirm));
    push("beq_addr", 32'h1C);    pop_chk(branch_addr);
    PC_in = 32'h1C; PC_add_4_in = 32'h20; inst_from_rom = 32'hDEAD_BEEF;
    tick();
    push("flush_inst", 32'h0);    pop_chk(ifid_inst);
    push("flush_valid", 32'h0);   pop_chk(32'(ifid_valid));
    push("flush_count", 32'h1);   pop_chk(flush_count);
    push("flush_pc", 32'h1C);     pop_chk(ifid_pc);
    push("flush_confirm", 32'h0); pop_chk(32'(branch_confirm));

    // same beq, rt forwarded from EX/MEM ALU result
    PC_in = 32'hC; PC_add_4_in = 32'h10; inst_from_rom = 32'h1022_0003;
    tick();
    rs_data = 32'd7; rt_data = 32'd9;
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd2; exmem_alu_result = 32'd7;
    #1;
    push("fwd_confirm", 32'h1); pop_chk(32'(branch_confirm));
    push("fwd_stall", 32'h0);   pop_chk(32'(stall));
    exmem_mem_read = 1'b1;
    #1;
    push("memload_stall", 32'h1);   pop_chk(32'(stall));
    push("memload_confirm", 32'h0); pop_chk(32'(branch_confirm));
    tick();
    push("memload_hold", 32'h1022_0003); pop_chk(ifid_inst);
    push("memload_cycles", 32'h2);       pop_chk(stall_cycles);
    exmem_mem_read = 1'b0; exmem_reg_write = 1'b0;
    idex_reg_write = 1'b1; idex_write_reg = 5'd1;
    #1;
    push("exdep_stall", 32'h1); pop_chk(32'(stall));
    idex_reg_write = 1'b0;
    #1;
    push("nofwd_confirm", 32'h0); pop_chk(32'(branch_confirm));

    // bne $0,$0,-1: $0 never hazards, negative offset wraps back
    PC_in = 32'h4; PC_add_4_in = 32'h8; inst_from_rom = 32'h1400_FFFF;
    tick();
    rs_data = 32'd0; rt_data = 32'd0;
    idex_reg_write = 1'b1; idex_write_reg = 5'd0;
    #1;
    push("r0_stall", 32'h0);   pop_chk(32'(stall));
    push("r0_confirm", 32'h0); pop_chk(32'(branch_confirm));
    push("neg_addr", 32'h4);   pop_chk(branch_addr);
    idex_reg_write = 1'b0;

    // reset lands mid-stall with nonzero counters
    PC_in = 32'h8; PC_add_4_in = 32'hC; inst_from_rom = 32'h010A_4820;
    tick();
    idex_mem_read = 1'b1; idex_write_reg = 5'd8;
    #1;
    push("pre_reset_stall", 32'h1); pop_chk(32'(stall));
    tick();
    push("pre_reset_cycles", 32'h3); pop_chk(stall_cycles);
    #2 reset = 1'b1;
    #1;
    expect_reset_state("async_reset");

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register plus ID-stage hazard and branch-resolution unit for the 5-stage MIPS pipeline.
- Captures PC, PC+4 and the fetched instruction from the fetch stage every CPUCLK edge.
- Detects load-use and branch-operand hazards and resolves beq/bne in ID.
- Drives stall, branch_confirm and branch_addr back to the fetch stage, and a bubble request to ID/EX.

Parameters:
- NOP_INST, 32'h00000000, instruction word inserted on flush/reset (sll $0,$0,0)
- CNT_W, 32, width of the performance counters

Ports:
- CPUCLK input 1 pipeline clock, all state on posedge
- reset input 1 asynchronous, active-high; clears all registers
- PC_in input 32 PC of the instruction being fetched
- PC_add_4_in input 32 PC+4 from fetch
- inst_from_rom input 32 fetched instruction, valid before CPUCLK posedge
- rs_data input 32 register-file read of ifid_inst[25:21]
- rt_data input 32 register-file read of ifid_inst[20:16]
- idex_mem_read input 1 instruction in EX is a load
- idex_reg_write input 1 instruction in EX writes a register
- idex_write_reg input 5 destination register of EX instruction
- exmem_mem_read input 1 instruction in MEM is a load
- exmem_reg_write input 1 instruction in MEM writes a register
- exmem_write_reg input 5 destination register of MEM instruction
- exmem_alu_result input 32 ALU result held in EX/MEM
- ifid_pc output 32 registered PC
- ifid_pc_add_4 output 32 registered PC+4
- ifid_inst output 32 registered instruction
- ifid_valid output 1 registered slot holds a real instruction
- stall output 1 hold PC and IF/ID (combinational)
- bubble_idex output 1 load NOP into ID/EX this cycle (equals stall)
- branch_confirm output 1 taken branch resolved in ID (combinational)
- branch_addr output 32 branch target (combinational)
- stall_cycles output CNT_W count of cycles with stall=1
- flush_count output CNT_W count of taken-branch flushes

Behaviour:
- Reset (async): ifid_pc=0, ifid_pc_add_4=0, ifid_inst=NOP_INST, ifid_valid=0, both counters=0. Combinational outputs are then 0 because NOP_INST raises no hazard.
- Field decode from ifid_inst:
  - op=[31:26], rs=[25:21], rt=[20:16], imm=[15:0]
  - is_branch = (op==6'h04) or (op==6'h05)
  - uses_rt = (op==0) or is_branch or (op==6'h2B)
  - Register $0 never causes a hazard.
- Load-use stall: idex_mem_read && idex_write_reg!=0 && (idex_write_reg==rs || (uses_rt && idex_write_reg==rt)).
- Branch stall (is_branch only):
  - idex_reg_write && idex_write_reg!=0 matches rs/rt, because the ALU result is not yet available.
  - Or exmem_mem_read && exmem_write_reg!=0 matches rs/rt.
- stall = load-use stall OR branch stall. The condition is re-evaluated every cycle, so a load then dependent beq yields 2 stall cycles.
- Branch operands:
  - rs_val = exmem_alu_result when exmem_reg_write && !exmem_mem_read && exmem_write_reg!=0 && exmem_write_reg==rs; otherwise rs_data. rt_val is formed the same way.
  - The register file writes before it reads in the same cycle, so WB needs no forwarding here.
- branch_addr = ifid_pc_add_4 + ({{14{imm[15]}},imm,2'b00}); 32-bit wraparound, carry discarded.
- branch_confirm = ifid_valid && is_branch && !stall && (op==04 ? rs_val==rt_val : rs_val!=rt_val). It is never 1 while stall=1.
- Register update on posedge CPUCLK, in priority order:
  1. branch_confirm=1: flush. ifid_inst<=NOP_INST, ifid_valid<=0, ifid_pc/ifid_pc_add_4 loaded from the inputs, flush_count++.
  2. Else stall=1: all IF/ID registers hold, stall_cycles++.
  3. Else: load PC_in, PC_add_4_in, inst_from_rom, ifid_valid<=1.
- Latency: an instruction presented at edge N appears on ifid_* after edge N. The branch decision is available in the same cycle it sits in IF/ID, giving a 1-instruction penalty (squashed).
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-branch takes effect immediately; no pending state survives reset.

Test Plan:
- Reset, then feed inst 0x20080005 at PC 0 → after 1 edge: ifid_inst=0x20080005, ifid_pc=0, ifid_pc_add_4=4, ifid_valid=1, stall=0.
- lw $8 in EX (idex_mem_read=1, idex_write_reg=8), ifid_inst=add $9,$8,$10 (0x010A4820) → stall=1, bubble_idex=1. After the edge, ifid holds the same value and stall_cycles=1. Deassert idex_mem_read → stall=0.
- ifid_pc_add_4=0x10, ifid_inst=beq $1,$2,+3 (0x10220003), rs_data=rt_data=7 → branch_confirm=1, branch_addr=0x1C. Next edge: ifid_inst=0, ifid_valid=0, flush_count=1.
- Same beq with rs_data=7, rt_data=9, exmem_reg_write=1, exmem_write_reg=2, exmem_alu_result=7 → forwarded compare taken, branch_confirm=1. With exmem_mem_read=1 instead → stall=1, branch_confirm=0.
- bne $0,$0 with idex_reg_write=1, idex_write_reg=0 → no stall, branch_confirm=0. Negative offset imm=0xFFFF with ifid_pc_add_4=0x8 → branch_addr=0x4.
- Assert reset while stall=1 and counters are nonzero → all outputs return to their reset values immediately, without waiting for CPUCLK.
